// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, status flags, and the write-back FSM/exception enums.
package alu_pkg;

  // Encodings 4'd9..4'd15 are unassigned; write-back treats them as single-write ops.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MULT = 4'd2,
    DIV  = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8
  } control_e;

  typedef struct packed {
    logic zero;
    logic div0;
    logic overflow;
    logic sign;
  } status_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DIV0 = 2'd1,
    OVF  = 2'd2
  } exc_cause_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    EXC   = 2'd3
  } wb_state_e;

  // MULT and DIV carry a second result half (product-high / remainder).
  function automatic logic is_muldiv(input control_e c);
    return (c == MULT) || (c == DIV);
  endfunction

  function automatic logic is_addsub(input control_e c);
    return (c == ADD) || (c == SUB);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU result write-back: low half to dest, upper half of MULT/DIV to HI_REG, flag capture.
// Exception reporting (div0 trap, ADD/SUB overflow pulse) is built only with ALU_WB_EXC_EN.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int                REG_AW = 4,
  parameter logic [REG_AW-1:0] HI_REG = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a result is taken on a rising edge where in_valid and in_ready are both 1;
  // in_valid may be raised or dropped freely, the inputs only matter at the accepting edge.
  input  logic              in_valid,
  output logic              in_ready,
  input  control_e          control,
  input  logic [31:0]       alu_out,
  input  status_t           stat,
  input  logic [REG_AW-1:0] dest,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output status_t           flags,
  output logic              exc,
  output exc_cause_e        exc_cause,
  output wb_state_e         dbg_state
);

  wb_state_e   state;
  logic [15:0] hi_q;
  logic        split_q;

  logic        acc;
  logic        split;
  logic        div0_trap;
  logic        ovf_trap;
  logic [15:0] lo_data;

  always_comb begin
    acc   = in_valid && in_ready;
    split = is_muldiv(control) && !stat.div0;
`ifdef ALU_WB_EXC_EN
    div0_trap = stat.div0;
    ovf_trap  = stat.overflow && is_addsub(control);
    lo_data   = alu_out[15:0];
`else
    // Without the trap, a divide-by-zero still retires as a zero written to dest.
    div0_trap = 1'b0;
    ovf_trap  = 1'b0;
    lo_data   = stat.div0 ? 16'h0000 : alu_out[15:0];
`endif
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      flags     <= '0;
      exc       <= 1'b0;
      exc_cause <= NONE;
      hi_q      <= '0;
      split_q   <= 1'b0;
    end else begin
      // Write and exception outputs are single-cycle strobes; idle value is all zero.
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      exc       <= 1'b0;
      exc_cause <= NONE;
      case (state)
        IDLE, WR_LO: begin
          if (acc) begin
            flags <= stat;
            if (div0_trap) begin
              state    <= EXC;
              in_ready <= 1'b0;
              split_q  <= 1'b0;
              exc       <= 1'b1;
              exc_cause <= DIV0;
            end else begin
              state    <= WR_LO;
              wr_en    <= 1'b1;
              wr_addr  <= dest;
              wr_data  <= lo_data;
              hi_q     <= alu_out[31:16];
              split_q  <= split;
              in_ready <= !split;
              if (ovf_trap) begin
                exc       <= 1'b1;
                exc_cause <= OVF;
              end
            end
          end else if (state == WR_LO && split_q) begin
            state    <= WR_HI;
            wr_en    <= 1'b1;
            wr_addr  <= HI_REG;
            wr_data  <= hi_q;
            in_ready <= 1'b0;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        WR_HI: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          split_q  <= 1'b0;
        end
`ifdef ALU_WB_EXC_EN
        EXC: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
